// File: rtl/osd_pkg.sv
// rtl/osd_pkg.sv - shared constants, mode encodings and fill helper for the level-bar overlay
package osd_pkg;

   // Counter width for the x/y raster position and number of bar segments
   localparam int CNT_W   = 12;
   localparam int SEG_CNT = 8;

   // Overlay colours
   localparam logic [23:0] COL_BRIGHT   = 24'hFFFF00;
   localparam logic [23:0] COL_CONTRAST = 24'h00FFFF;
   localparam logic [23:0] COL_EMPTY    = 24'h404040;
   localparam logic [23:0] COL_BORDER   = 24'hFFFFFF;

   // mode_sel encodings; both hidden codes disable the overlay
   typedef enum logic [1:0] {
      MODE_HIDDEN     = 2'd0,
      MODE_BRIGHT     = 2'd1,
      MODE_CONTRAST   = 2'd2,
      MODE_HIDDEN_ALT = 2'd3
   } osd_mode_e;

   // floor(level/10) clamped to 7, as a compare chain instead of a divider
   function automatic logic [2:0] fill_from_level(input logic [7:0] lvl);
      logic [2:0] f;
      if      (lvl >= 8'd70) f = 3'd7;
      else if (lvl >= 8'd60) f = 3'd6;
      else if (lvl >= 8'd50) f = 3'd5;
      else if (lvl >= 8'd40) f = 3'd4;
      else if (lvl >= 8'd30) f = 3'd3;
      else if (lvl >= 8'd20) f = 3'd2;
      else if (lvl >= 8'd10) f = 3'd1;
      else                   f = 3'd0;
      return f;
   endfunction

endpackage

// File: rtl/osd_timing.sv
// rtl/osd_timing.sv - raster x/y counters, Vsync/De edge detection and frame_valid
module osd_timing
   import osd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             vsync_i,
   input  logic             de_i,
   output logic [CNT_W-1:0] x_o,
   output logic [CNT_W-1:0] y_o,
   output logic             vs_rise_o,
   output logic             frame_valid_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             vs_prev_q, vs_prev_d;
   logic             de_prev_q, de_prev_d;
   logic             fv_q, fv_d;
   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic             vs_rise;
   logic             de_fall;

   // Next-state: x counts active pixels in the line, y counts completed lines in the frame
   always_comb begin
      vs_rise   = vsync_i & ~vs_prev_q;
      de_fall   = ~de_i & de_prev_q;
      vs_prev_d = vsync_i;
      de_prev_d = de_i;
      fv_d      = fv_q | vs_rise;

      x_d = x_q;
      if (de_i) begin
         if (x_q != CNT_MAX) x_d = x_q + 1'b1;
      end else begin
         x_d = '0;
      end

      // A frame start clears y even if a line ends on the same cycle
      y_d = y_q;
      if (vs_rise) begin
         y_d = '0;
      end else if (de_fall && (y_q != CNT_MAX)) begin
         y_d = y_q + 1'b1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_prev_q <= 1'b0;
         de_prev_q <= 1'b0;
         fv_q      <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
      end else begin
         vs_prev_q <= vs_prev_d;
         de_prev_q <= de_prev_d;
         fv_q      <= fv_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

   assign x_o           = x_q;
   assign y_o           = y_q;
   assign vs_rise_o     = vs_rise;
   assign frame_valid_o = fv_q;

endmodule

// File: rtl/osd_level_bar.sv
// rtl/osd_level_bar.sv - segmented level-bar overlay on a video stream, 2-cycle pipeline
// Optional feature: define OSD_BORDER_EN to draw a 1-pixel white frame around the bar.
module osd_level_bar
   import osd_pkg::*;
#(
   parameter int BAR_X0 = 16,
   parameter int BAR_Y0 = 16,
   parameter int SEG_W  = 16,
   parameter int BAR_H  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Vsync,
   input  logic        Hsync,
   input  logic        De,
   input  logic [23:0] RGB,
   input  logic [7:0]  level,
   input  logic [1:0]  mode_sel,
   output logic        Vsync_o,
   output logic        Hsync_o,
   output logic        De_o,
   output logic [23:0] RGB_o
);

   localparam int SUB_W = (SEG_W > 1) ? $clog2(SEG_W) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SEG_W - 1);

   // Region bounds widened by one bit so the upper limits never wrap
   localparam logic [CNT_W:0] X_LO = (CNT_W+1)'(BAR_X0);
   localparam logic [CNT_W:0] X_HI = (CNT_W+1)'(BAR_X0 + SEG_CNT * SEG_W);
   localparam logic [CNT_W:0] Y_LO = (CNT_W+1)'(BAR_Y0);
   localparam logic [CNT_W:0] Y_HI = (CNT_W+1)'(BAR_Y0 + BAR_H);

   logic [CNT_W-1:0] x, y;
   logic             vs_rise, frame_valid;

   logic [7:0]       level_q, level_d;
   osd_mode_e        mode_q, mode_d;
   logic [SUB_W-1:0] seg_sub_q, seg_sub_d;
   logic [3:0]       seg_k_q, seg_k_d;

   logic             vs1_q, hs1_q, de1_q;
   logic [23:0]      rgb1_q, rgb1_d;
   logic             vs2_q, hs2_q, de2_q;
   logic [23:0]      rgb2_q;

   logic [CNT_W:0]   x_ext, y_ext;
   logic             in_x, in_y, overlay_on;
   logic [2:0]       fill;
   logic [23:0]      fill_col;
`ifdef OSD_BORDER_EN
   logic             in_bx, in_by;
`endif

   osd_timing u_timing (
      .clk           (clk),
      .rst           (rst),
      .vsync_i       (Vsync),
      .de_i          (De),
      .x_o           (x),
      .y_o           (y),
      .vs_rise_o     (vs_rise),
      .frame_valid_o (frame_valid)
   );

   // Region decode, segment tracking, frame latch and overlay colour selection
   always_comb begin
      x_ext = {1'b0, x};
      y_ext = {1'b0, y};
      in_x  = (x_ext >= X_LO) && (x_ext < X_HI);
      in_y  = (y_ext >= Y_LO) && (y_ext < Y_HI);

      // Settings only move at frame start so a frame never shows a torn bar
      level_d = vs_rise ? level : level_q;
      mode_d  = vs_rise ? osd_mode_e'(mode_sel) : mode_q;

      // Sub-counter sits at 0 until the first bar column, then walks segments
      seg_sub_d = '0;
      seg_k_d   = '0;
      if (De && in_x) begin
         if (seg_sub_q == SUB_LAST) begin
            seg_sub_d = '0;
            seg_k_d   = seg_k_q + 4'd1;
         end else begin
            seg_sub_d = seg_sub_q + 1'b1;
            seg_k_d   = seg_k_q;
         end
      end

      overlay_on = frame_valid && De &&
                   ((mode_q == MODE_BRIGHT) || (mode_q == MODE_CONTRAST));
      fill       = fill_from_level(level_q);
      fill_col   = (mode_q == MODE_BRIGHT) ? COL_BRIGHT : COL_CONTRAST;

`ifdef OSD_BORDER_EN
      in_bx = ((x_ext + 1'b1) >= X_LO) && (x_ext <= X_HI);
      in_by = ((y_ext + 1'b1) >= Y_LO) && (y_ext <= Y_HI);
`endif

      rgb1_d = RGB;
      if (overlay_on && in_x && in_y) begin
         rgb1_d = ({1'b0, fill} > seg_k_q) ? fill_col : COL_EMPTY;
      end
`ifdef OSD_BORDER_EN
      else if (overlay_on && in_bx && in_by) begin
         rgb1_d = COL_BORDER;
      end
`endif
   end

   // Frame latch, segment counter and the two aligned pipeline stages
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q   <= '0;
         mode_q    <= MODE_HIDDEN;
         seg_sub_q <= '0;
         seg_k_q   <= '0;
         vs1_q     <= 1'b0;
         hs1_q     <= 1'b0;
         de1_q     <= 1'b0;
         rgb1_q    <= '0;
         vs2_q     <= 1'b0;
         hs2_q     <= 1'b0;
         de2_q     <= 1'b0;
         rgb2_q    <= '0;
      end else begin
         level_q   <= level_d;
         mode_q    <= mode_d;
         seg_sub_q <= seg_sub_d;
         seg_k_q   <= seg_k_d;
         vs1_q     <= Vsync;
         hs1_q     <= Hsync;
         de1_q     <= De;
         rgb1_q    <= rgb1_d;
         vs2_q     <= vs1_q;
         hs2_q     <= hs1_q;
         de2_q     <= de1_q;
         rgb2_q    <= rgb1_q;
      end
   end

   assign Vsync_o = vs2_q;
   assign Hsync_o = hs2_q;
   assign De_o    = de2_q;
   assign RGB_o   = rgb2_q;

endmodule

// File: tb/tb_osd_level_bar.sv
// tb/tb_osd_level_bar.sv - randomized frames against a raster-level model of the level bar
module tb_osd_level_bar;

   logic        clk = 1'b0;
   logic        rst, Vsync, Hsync, De;
   logic [23:0] RGB;
   logic [7:0]  level;
   logic [1:0]  mode_sel;
   logic        Vsync_o, Hsync_o, De_o;
   logic [23:0] RGB_o;

   always #5 clk = ~clk;

   osd_level_bar #(.BAR_X0(8), .BAR_Y0(4), .SEG_W(4), .BAR_H(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .Vsync    (Vsync),
      .Hsync    (Hsync),
      .De       (De),
      .RGB      (RGB),
      .level    (level),
      .mode_sel (mode_sel),
      .Vsync_o  (Vsync_o),
      .Hsync_o  (Hsync_o),
      .De_o     (De_o),
      .RGB_o    (RGB_o)
   );

   typedef struct {
      bit          valid;
      logic        vs, hs, de;
      logic [23:0] rgb;
      bit          has_lit;
      logic [23:0] lit;
      int          line, pix;
   } exp_t;

   typedef struct {
      int          line, pix, kind;
      logic [23:0] val;
   } lit_t;

   exp_t hist [8];
   lit_t lits [$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   bit   m_fv, m_prev_vs;
   int   m_level, m_mode;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected pixel from raster coordinates and the settings latched at frame start
   function automatic logic [23:0] model_rgb(input int line, input int pix, input bit de,
                                             input logic [23:0] rgb);
      int  fill, seg;
      bit  on;
      on   = m_fv && de && (m_mode == 1 || m_mode == 2);
      fill = m_level / 10;
      if (fill > 7) fill = 7;
      if (on && line >= 4 && line < 8 && pix >= 8 && pix < 40) begin
         seg = (pix - 8) / 4;
         if (seg < fill) return (m_mode == 1) ? 24'hFFFF00 : 24'h00FFFF;
         return 24'h404040;
      end
`ifdef OSD_BORDER_EN
      if (on && line >= 3 && line <= 8 && pix >= 7 && pix <= 40) return 24'hFFFFFF;
`endif
      return rgb;
   endfunction

   task automatic zero_slot(input int s);
      hist[s].valid   = 1'b1;
      hist[s].vs      = 1'b0;
      hist[s].hs      = 1'b0;
      hist[s].de      = 1'b0;
      hist[s].rgb     = '0;
      hist[s].has_lit = 1'b0;
      hist[s].line    = -1;
      hist[s].pix     = -1;
   endtask

   // One input cycle: drive pins, record what the output must be two cycles later
   task automatic drive(input bit r, input bit vs, input bit hs, input bit de,
                        input int line, input int pix, input int lvl, input int md,
                        input int lk, input logic [23:0] lv);
      int          s, sp;
      logic [23:0] px;
      @(posedge clk);
      #1;
      px       = 24'($urandom);
      rst      = r;
      Vsync    = vs;
      Hsync    = hs;
      De       = de;
      RGB      = px;
      level    = 8'(lvl);
      mode_sel = 2'(md);
      s        = cyc & 7;
      sp       = (cyc - 1) & 7;
      if (r) begin
         zero_slot(s);
         zero_slot(sp);
         m_fv      = 1'b0;
         m_level   = 0;
         m_mode    = 0;
         m_prev_vs = 1'b0;
      end else begin
         hist[s].valid   = 1'b1;
         hist[s].vs      = vs;
         hist[s].hs      = hs;
         hist[s].de      = de;
         hist[s].rgb     = model_rgb(line, pix, de, px);
         hist[s].has_lit = (lk != 0);
         hist[s].lit     = (lk == 2) ? px : lv;
         hist[s].line    = line;
         hist[s].pix     = pix;
         if (vs && !m_prev_vs) begin
            m_fv    = 1'b1;
            m_level = lvl;
            m_mode  = md;
         end
         m_prev_vs = vs;
      end
   endtask

   task automatic add_lit(input int line, input int pix, input int kind, input logic [23:0] val);
      lit_t l;
      l.line = line;
      l.pix  = pix;
      l.kind = kind;
      l.val  = val;
      lits.push_back(l);
   endtask

   // 64x16 active frame; optional level/mode change and optional reset pulse at a pixel
   task automatic frame(input int lvl, input int md, input int chg_line, input int lvl2,
                        input int md2, input int rst_line, input int rst_pix);
      int          cl, cm, kind;
      logic [23:0] val;
      cl = lvl;
      cm = md;
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, -1, -1, cl, cm, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, -1, -1, cl, cm, 0, 0);
      for (int ln = 0; ln < 16; ln++) begin
         for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, -1, -1, cl, cm, 0, 0);
         for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, -1, -1, cl, cm, 0, 0);
         for (int p = 0; p < 64; p++) begin
            if (ln == chg_line && p == 0) begin
               cl = lvl2;
               cm = md2;
            end
            kind = 0;
            val  = '0;
            foreach (lits[k]) begin
               if (lits[k].line == ln && lits[k].pix == p) begin
                  kind = lits[k].kind;
                  val  = lits[k].val;
               end
            end
            drive(ln == rst_line && p == rst_pix, 0, 0, 1, ln, p, cl, cm, kind, val);
         end
         for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, -1, -1, cl, cm, 0, 0);
      end
      lits.delete();
   endtask

   // Compare outputs against the slot driven two cycles earlier
   always @(negedge clk) begin
      exp_t e;
      if (cyc >= 2) begin
         e = hist[(cyc - 2) & 7];
         if (e.valid) begin
            checks++;
            if ({Vsync_o, Hsync_o, De_o, RGB_o} !== {e.vs, e.hs, e.de, e.rgb}) begin
               errors++;
               $display("FAIL pipe cyc=%0d line=%0d pix=%0d got vs=%b hs=%b de=%b rgb=%06h want vs=%b hs=%b de=%b rgb=%06h",
                        cyc, e.line, e.pix, Vsync_o, Hsync_o, De_o, RGB_o, e.vs, e.hs, e.de, e.rgb);
            end
            if (e.has_lit) begin
               checks++;
               if (RGB_o !== e.lit) begin
                  errors++;
                  $display("FAIL literal line=%0d pix=%0d got rgb=%06h want rgb=%06h",
                           e.line, e.pix, RGB_o, e.lit);
               end
            end
         end
      end
   end

   initial begin
      int lv, md, cl, l2, m2, rl;
      for (int i = 0; i < 8; i++) hist[i].valid = 1'b0;
      rst = 1'b1; Vsync = 1'b0; Hsync = 1'b0; De = 1'b0; RGB = '0; level = '0; mode_sel = '0;
      m_fv = 1'b0; m_prev_vs = 1'b0; m_level = 0; m_mode = 0;

      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, -1, -1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, -1, -1, 0, 0, 0, 0);

      // level 30, brightness: 3 filled segments
      add_lit(5, 8, 1, 24'hFFFF00);
      add_lit(5, 19, 1, 24'hFFFF00);
      add_lit(5, 20, 1, 24'h404040);
      add_lit(7, 39, 1, 24'h404040);
      add_lit(5, 41, 2, 0);
      add_lit(2, 10, 2, 0);
      add_lit(9, 10, 2, 0);
`ifdef OSD_BORDER_EN
      add_lit(3, 7, 1, 24'hFFFFFF);
      add_lit(8, 40, 1, 24'hFFFFFF);
`else
      add_lit(3, 7, 2, 0);
      add_lit(8, 40, 2, 0);
`endif
      frame(30, 1, -1, 0, 0, -1, -1);

      // level moves to 50 mid-frame; takes effect next frame
      add_lit(7, 19, 1, 24'hFFFF00);
      add_lit(7, 20, 1, 24'h404040);
      frame(30, 1, 6, 50, 1, -1, -1);
      add_lit(4, 27, 1, 24'hFFFF00);
      add_lit(4, 28, 1, 24'h404040);
      frame(50, 1, -1, 0, 0, -1, -1);

      // hidden modes pass everything through
      add_lit(5, 10, 2, 0);
      frame(30, 0, -1, 0, 0, -1, -1);
      add_lit(5, 10, 2, 0);
      frame(70, 3, -1, 0, 0, -1, -1);

      // level above range clamps to 7 segments, contrast colour
      add_lit(4, 35, 1, 24'h00FFFF);
      add_lit(4, 36, 1, 24'h404040);
      add_lit(7, 8, 1, 24'h00FFFF);
      frame(200, 2, -1, 0, 0, -1, -1);

      // reset mid-frame: no overlay until the next frame start
      add_lit(5, 20, 2, 0);
      add_lit(6, 10, 2, 0);
      frame(30, 1, -1, 0, 0, 5, 10);
      add_lit(4, 8, 1, 24'hFFFF00);
      frame(30, 1, -1, 0, 0, -1, -1);

      // random settings, random mid-frame changes, one random reset
      for (int f = 0; f < 5; f++) begin
         lv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 80);
         md = $urandom_range(0, 3);
         cl = $urandom_range(0, 15);
         l2 = $urandom_range(0, 255);
         m2 = $urandom_range(0, 3);
         rl = (f == 3) ? $urandom_range(0, 15) : -1;
         frame(lv, md, cl, l2, m2, rl, $urandom_range(0, 63));
      end

      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, -1, -1, 0, 0, 0, 0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/osd_level_bar.md
OSD_LEVEL_BAR -- requirements
Module: osd_level_bar

Interface
REQ-001 The block SHALL have parameter BAR_X0, default 16: first bar pixel column, counted from active-line start.
REQ-002 The block SHALL have parameter BAR_Y0, default 16: first bar line, counted from frame start.
REQ-003 The block SHALL have parameter SEG_W, default 16: pixels per segment.
REQ-004 The block SHALL have parameter BAR_H, default 8: bar height in lines.
REQ-005 The block SHALL have port clk, input, 1 bit: pixel clock; the block's only clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have ports Vsync, Hsync and De, input, 1 bit each: upstream timing; Vsync and De are active-high.
REQ-008 The block SHALL have port RGB, input, 24 bits: upstream pixel, {R,G,B}.
REQ-009 The block SHALL have port level, input, 8 bits: current adjustment value, nominally 0..70 in steps of 10.
REQ-010 The block SHALL have port mode_sel, input, 2 bits: 0 = hidden, 1 = brightness, 2 = contrast, 3 = hidden.
REQ-011 The block SHALL have ports Vsync_o, Hsync_o and De_o, output, 1 bit each: delayed timing.
REQ-012 The block SHALL have port RGB_o, output, 24 bits: pixel with overlay applied.

Function
REQ-013 All outputs SHALL be delayed exactly 2 clk cycles relative to the corresponding inputs; timing and pixel paths SHALL stay aligned.
REQ-014 The x counter (12 bits) SHALL count De-high pixels, clear when De falls, and saturate at 4095.
REQ-015 The y counter (12 bits) SHALL increment on each De falling edge, clear on each Vsync rising edge, and saturate at 4095; a clear SHALL win over a simultaneous increment.
REQ-016 On each Vsync rising edge, level and mode_sel SHALL be latched; changes mid-frame SHALL take effect at the next frame only.
REQ-017 The fill count SHALL be floor(latched level / 10), clamped to 7, computed by a compare chain with no divider.
REQ-018 The bar region SHALL be x in [BAR_X0, BAR_X0 + 8*SEG_W) and y in [BAR_Y0, BAR_Y0 + BAR_H).
REQ-019 The segment index SHALL come from a SEG_W pixel sub-counter with no divider.
REQ-020 Inside the region, with De high and latched mode 1 or 2, a pixel in segment k < fill SHALL be the fill colour: 24'hFFFF00 for mode 1, 24'h00FFFF for mode 2.
REQ-021 Inside the region, under the same conditions, a pixel in segment k >= fill SHALL be 24'h404040.
REQ-022 All other pixels SHALL pass through unmodified.
REQ-023 With latched mode 0 or 3, RGB_o SHALL equal RGB delayed by 2 cycles.
REQ-024 Overlay SHALL be suppressed until the first Vsync rising edge after reset; a frame_valid flag SHALL provide this.

Reset
REQ-025 While rst is high, Vsync_o, Hsync_o, De_o and RGB_o SHALL be 0 on the next clk edge.
REQ-026 While rst is high, the counters, latched level, latched mode and frame_valid SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame; the pipeline SHALL output 0 until the 2-cycle refill after release.

Configuration
REQ-028 When OSD_BORDER_EN is defined, a 1-pixel 24'hFFFFFF border SHALL be drawn immediately outside the bar region when overlay is active.
REQ-029 When OSD_BORDER_EN is undefined, no border logic SHALL be present and pixels outside the region SHALL pass through.

Structure
REQ-030 Package osd_pkg SHALL hold the colour constants, the mode_sel encodings, the counter width (12), and the segment count (8).
REQ-031 Sub-module osd_timing SHALL contain the x/y counters, edge detection and frame_valid; osd_level_bar SHALL instantiate it and own the level latch, compare chain and 2-stage output pipeline.

Verification
All scenarios use a 64x16 active frame with BAR_X0=8, BAR_Y0=4, SEG_W=4, BAR_H=4.
REQ-032 level=30, mode=1: on lines 4..7, pixels 8..19 SHALL be FFFF00, pixels 20..39 SHALL be 404040, and all other pixels SHALL pass through, each 2 cycles after input.
REQ-033 level changes 30->50 during line 6: the frame SHALL finish with 3 filled segments, and the next frame SHALL show 5 (pixels 8..27 FFFF00).
REQ-034 mode=0 (also mode=3), random RGB: RGB_o and the sync outputs SHALL equal the inputs delayed 2 cycles, bit-exact.
REQ-035 level=200, mode=2: 7 segments (pixels 8..35) SHALL be 00FFFF, and pixels 36..39 SHALL be 404040.
REQ-036 rst pulsed for 1 cycle at line 5, pixel 10: all outputs SHALL be 0 on the next cycle, and no overlay SHALL appear before the next Vsync rise.
REQ-037 With OSD_BORDER_EN defined: pixels (7,3) and (40,8) SHALL be FFFFFF; with it undefined they SHALL pass through.
